// File: rtl/if_id_stage_reg_if.sv
// Handshake bundle between fetch, the IF/ID skid register and decode.
// The slave modport is the stage itself; the master is whoever drives fetch/decode.
interface if_id_stage_reg_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    PC_IN;
    logic [INSTR_W-1:0] INSTRUCTION_IN;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    PC_OUT;
    logic [INSTR_W-1:0] INSTRUCTION_OUT;
    logic [CNT_W-1:0]   stall_count;

    modport slave (
        input  in_valid, PC_IN, INSTRUCTION_IN, flush, out_ready,
        output in_ready, out_valid, PC_OUT, INSTRUCTION_OUT, stall_count
    );

    modport master (
        output in_valid, PC_IN, INSTRUCTION_IN, flush, out_ready,
        input  in_ready, out_valid, PC_OUT, INSTRUCTION_OUT, stall_count
    );
endinterface

// File: rtl/if_id_stage_reg.sv
// Two-entry IF/ID skid register: head drives decode, skid absorbs one extra fetch
// so in_ready depends only on registered state. Also counts decode back-pressure cycles.
module if_id_stage_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    if_id_stage_reg_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic [CNT_W-1:0]   stall_cnt;

    logic accept;
    logic release_head;
    logic load_head_in;
    logic load_head_skid;
    logic load_skid;

    assign bus.in_ready        = (state != TWO);
    assign bus.out_valid       = (state != EMPTY);
    assign bus.PC_OUT          = head_pc;
    assign bus.INSTRUCTION_OUT = head_instr;
    assign bus.stall_count     = stall_cnt;

    assign accept       = bus.in_valid & bus.in_ready;
    assign release_head = bus.out_valid & bus.out_ready;

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !release_head) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (release_head && !accept) begin
                    state_next = EMPTY;
                end else if (accept && release_head) begin
                    load_head_in = 1'b1;
                end
            end
            TWO: begin
                if (release_head) begin
                    state_next     = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A redirect drops everything in flight but leaves the head data visible.
        if (bus.flush) begin
            state_next     = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_pc    <= '0;
            head_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state <= state_next;
            if (load_head_in) begin
                head_pc    <= bus.PC_IN;
                head_instr <= bus.INSTRUCTION_IN;
            end else if (load_head_skid) begin
                head_pc    <= skid_pc;
                head_instr <= skid_instr;
            end
            if (load_skid) begin
                skid_pc    <= bus.PC_IN;
                skid_instr <= bus.INSTRUCTION_IN;
            end
        end
    end

    // Counts on the flush cycle as well, since decode was still holding off a valid head.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/if_id_stage_reg.md
IF_ID_STAGE_REG -- requirements
Module: if_id_stage_reg

Interface
REQ-001 Parameter INSTR_W, default 32, instruction width in bits.
REQ-002 Parameter PC_W, default 32, program-counter width in bits.
REQ-003 Parameter CNT_W, default 16, stall-counter width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge; no delay statements.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  fetch stage presents a valid instruction (cache hit).
REQ-007 in_ready  output  1  block can accept an entry this cycle.
REQ-008 PC_IN  input  PC_W  PC of presented instruction.
REQ-009 INSTRUCTION_IN  input  INSTR_W  presented instruction word.
REQ-010 flush  input  1  discard all held entries (branch/exception redirect).
REQ-011 out_valid  output  1  head entry valid toward decode.
REQ-012 out_ready  input  1  decode consumes head entry this cycle.
REQ-013 PC_OUT  output  PC_W  PC of head entry.
REQ-014 INSTRUCTION_OUT  output  INSTR_W  instruction of head entry.
REQ-015 stall_count  output  CNT_W  cycles decode back-pressured a valid entry.

Function
REQ-016 Storage SHALL be two entries: head (drives outputs) and skid; FIFO order preserved.
REQ-017 accept = in_valid & in_ready; release = out_valid & out_ready.
REQ-018 State SHALL be EMPTY, ONE, or TWO (entries held); out_valid = (state != EMPTY).
REQ-019 in_ready SHALL = (state != TWO), decoded from registered state only; no combinational path from out_ready or in_valid.
REQ-020 EMPTY: accept -> ONE, head loads input.
REQ-021 ONE: accept & !release -> TWO, skid loads input; release & !accept -> EMPTY; accept & release -> ONE, head loads input.
REQ-022 TWO: release -> ONE, head loads skid; no release -> TWO, both held.
REQ-023 Latency: entry accepted at edge N SHALL be on outputs with out_valid=1 after edge N (one cycle); full throughput of one entry/cycle with out_ready held high.
REQ-024 in_valid=0 (miss) SHALL insert no entry; held entries unaffected.
REQ-025 Head/skid data SHALL change only on load; held while out_ready=0.
REQ-026 flush SHALL force state EMPTY at next edge, overriding accept and release in the same cycle; input that cycle discarded; PC_OUT/INSTRUCTION_OUT retain last value with out_valid=0.
REQ-027 Cycle after flush SHALL accept normally (in_ready=1).
REQ-028 stall_count SHALL increment by 1 each edge where out_valid=1 and out_ready=0, including the flush cycle; saturate at 2^CNT_W-1; unaffected by flush.
REQ-029 Outputs while out_valid=0 are don't-care except where REQ-026/REQ-031 fix them.

Reset
REQ-030 rst SHALL take priority over flush, accept, and release.
REQ-031 At the edge with rst=1: state EMPTY, out_valid=0, in_ready=1, PC_OUT=0, INSTRUCTION_OUT=0, stall_count=0, skid contents 0.
REQ-032 rst asserted mid-operation (state TWO) SHALL discard both entries at that edge; no entry emerges afterward.

Verification
REQ-033 Streaming: out_ready=1, in_valid=1 with PC_IN=0x100,0x104,0x108 on consecutive edges -> PC_OUT 0x100,0x104,0x108 one cycle later each, in_ready stays 1.
REQ-034 Back-pressure: out_ready=0, accept 0x200 then 0x204 -> in_ready=0 after second edge, PC_OUT holds 0x200; raise out_ready -> 0x200 then 0x204 released in order, none lost or duplicated.
REQ-035 Simultaneous: state ONE holding 0x300, accept 0x304 and release same edge -> PC_OUT=0x304, state ONE.
REQ-036 Flush: state TWO (0x400,0x404), flush=1 with in_valid=1 PC_IN=0x408 -> out_valid=0 next cycle, 0x408 never appears; next accept 0x500 emerges normally.
REQ-037 Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count saturates at 15; rst -> 0.
REQ-038 Reset mid-op: state TWO, rst=1 for one edge -> out_valid=0, in_ready=1, PC_OUT=0, INSTRUCTION_OUT=0, stall_count=0.
